// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared constants for the two-channel RAM-backed FIFO arbiter
package fifo_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int CH_DEPTH   = 2 ** (DEF_ADDR_W - 1);

    // Request indices, also the encoding held in the last-grant register
    localparam logic [1:0] REQ_PUSH0 = 2'd0;
    localparam logic [1:0] REQ_POP0  = 2'd1;
    localparam logic [1:0] REQ_PUSH1 = 2'd2;
    localparam logic [1:0] REQ_POP1  = 2'd3;

endpackage

// File: rtl/fifo_sp_ram.sv
// rtl/fifo_sp_ram.sv - single-port synchronous RAM with registered read data
module fifo_sp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Only the output register is reset; array contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/fifo_ram_arbiter.sv
// rtl/fifo_ram_arbiter.sv - two FIFOs sharing one single-port RAM, round-robin access
module fifo_ram_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push0_req,
    input  logic [DATA_W-1:0] push0_data,
    output logic              push0_gnt,
    input  logic              push1_req,
    input  logic [DATA_W-1:0] push1_data,
    output logic              push1_gnt,
    input  logic              pop0_req,
    output logic              pop0_gnt,
    input  logic              pop1_req,
    output logic              pop1_gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rch,
    output logic              full0,
    output logic              full1,
    output logic              empty0,
    output logic              empty1,
    output logic [ADDR_W-1:0] count0,
    output logic [ADDR_W-1:0] count1
);

    localparam int PTR_W = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] FULL_COUNT = ADDR_W'(1) << PTR_W;

    logic [PTR_W-1:0]  wptr0, rptr0, wptr1, rptr1;
    logic [1:0]        lg;
    logic [3:0]        elig;
    logic [3:0]        gnt;
    logic [1:0]        win;
    logic [1:0]        cand;
    logic              found;
    logic              acc_ch;
    logic              acc_push;
    logic [PTR_W-1:0]  acc_ptr;
    logic [ADDR_W-1:0] count0_next, count1_next;
    logic [DATA_W-1:0] acc_wdata;

    assign elig[REQ_PUSH0] = push0_req && !full0;
    assign elig[REQ_POP0]  = pop0_req  && !empty0;
    assign elig[REQ_PUSH1] = push1_req && !full1;
    assign elig[REQ_POP1]  = pop1_req  && !empty1;

    // Search starts just after the last winner so each requester gets a turn
    always_comb begin
        found = 1'b0;
        win   = lg;
        cand  = lg;
        gnt   = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = lg + 2'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (found) begin
            gnt[win] = 1'b1;
        end
    end

    assign push0_gnt = gnt[REQ_PUSH0];
    assign pop0_gnt  = gnt[REQ_POP0];
    assign push1_gnt = gnt[REQ_PUSH1];
    assign pop1_gnt  = gnt[REQ_POP1];

    assign acc_ch    = win[1];
    assign acc_push  = !win[0];
    assign acc_wdata = acc_ch ? push1_data : push0_data;

    always_comb begin
        acc_ptr = '0;
        case (win)
            REQ_PUSH0: acc_ptr = wptr0;
            REQ_POP0:  acc_ptr = rptr0;
            REQ_PUSH1: acc_ptr = wptr1;
            default:   acc_ptr = rptr1;
        endcase
    end

    always_comb begin
        count0_next = count0;
        count1_next = count1;
        if (gnt[REQ_PUSH0]) count0_next = count0 + ADDR_W'(1);
        if (gnt[REQ_POP0])  count0_next = count0 - ADDR_W'(1);
        if (gnt[REQ_PUSH1]) count1_next = count1 + ADDR_W'(1);
        if (gnt[REQ_POP1])  count1_next = count1 - ADDR_W'(1);
    end

    // Channel bit on top keeps pointer wrap inside each channel's half
    fifo_sp_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .en   (found && !rst),
        .we   (acc_push),
        .addr ({acc_ch, acc_ptr}),
        .wdata(acc_wdata),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr0  <= '0;
            rptr0  <= '0;
            wptr1  <= '0;
            rptr1  <= '0;
            count0 <= '0;
            count1 <= '0;
            full0  <= 1'b0;
            full1  <= 1'b0;
            empty0 <= 1'b1;
            empty1 <= 1'b1;
            lg     <= REQ_POP1;
            rvalid <= 1'b0;
            rch    <= 1'b0;
        end else begin
            if (found) lg <= win;
            if (gnt[REQ_PUSH0]) wptr0 <= wptr0 + PTR_W'(1);
            if (gnt[REQ_POP0])  rptr0 <= rptr0 + PTR_W'(1);
            if (gnt[REQ_PUSH1]) wptr1 <= wptr1 + PTR_W'(1);
            if (gnt[REQ_POP1])  rptr1 <= rptr1 + PTR_W'(1);
            count0 <= count0_next;
            count1 <= count1_next;
            full0  <= (count0_next == FULL_COUNT);
            full1  <= (count1_next == FULL_COUNT);
            empty0 <= (count0_next == '0);
            empty1 <= (count1_next == '0);
            rvalid <= found && !acc_push;
            if (found && !acc_push) rch <= acc_ch;
        end
    end

endmodule

// File: tb/tb_fifo_ram_arbiter.sv
// tb/tb_fifo_ram_arbiter.sv - directed self-checking bench for fifo_ram_arbiter
module tb_fifo_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       push0_req, push1_req, pop0_req, pop1_req;
    logic [7:0] push0_data, push1_data;
    logic       push0_gnt, push1_gnt, pop0_gnt, pop1_gnt;
    logic [7:0] rdata;
    logic       rvalid, rch;
    logic       full0, full1, empty0, empty1;
    logic [7:0] count0, count1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .push0_req(push0_req), .push0_data(push0_data), .push0_gnt(push0_gnt),
        .push1_req(push1_req), .push1_data(push1_data), .push1_gnt(push1_gnt),
        .pop0_req(pop0_req), .pop0_gnt(pop0_gnt),
        .pop1_req(pop1_req), .pop1_gnt(pop1_gnt),
        .rdata(rdata), .rvalid(rvalid), .rch(rch),
        .full0(full0), .full1(full1), .empty0(empty0), .empty1(empty1),
        .count0(count0), .count1(count1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        push0_req = 1'b0;
        push1_req = 1'b0;
        pop0_req  = 1'b0;
        pop1_req  = 1'b0;
    endtask

    task automatic apply_reset();
        clear_reqs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_push(input logic ch, input logic [7:0] d, output logic ok);
        ok = 1'b0;
        if (ch) begin push1_req = 1'b1; push1_data = d; end
        else    begin push0_req = 1'b1; push0_data = d; end
        for (int i = 0; i < 16 && !ok; i++) begin
            #1;
            ok = ch ? push1_gnt : push0_gnt;
            tick();
        end
        push0_req = 1'b0;
        push1_req = 1'b0;
    endtask

    task automatic do_pop(input logic ch, output logic ok, output logic rv,
                          output logic rc, output logic [7:0] d);
        ok = 1'b0;
        if (ch) pop1_req = 1'b1;
        else    pop0_req = 1'b1;
        for (int i = 0; i < 16 && !ok; i++) begin
            #1;
            ok = ch ? pop1_gnt : pop0_gnt;
            tick();
        end
        pop0_req = 1'b0;
        pop1_req = 1'b0;
        rv = rvalid;
        rc = rch;
        d  = rdata;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++;
        if ({count0, count1} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_counts: got %h/%h want 00/00", count0, count1);
        end
        vectors++;
        if ({empty0, empty1, full0, full1} !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_flags: got e0=%b e1=%b f0=%b f1=%b want 1 1 0 0",
                     empty0, empty1, full0, full1);
        end
        vectors++;
        if ({rvalid, rch, rdata} !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_rd: got rvalid=%b rch=%b rdata=%h want 0 0 00", rvalid, rch, rdata);
        end
        vectors++;
        if ({push0_gnt, pop0_gnt, push1_gnt, pop1_gnt} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_gnt: got %b%b%b%b want 0000", push0_gnt, pop0_gnt, push1_gnt, pop1_gnt);
        end
    endtask

    task automatic test_basic_ch0();
        logic [7:0] exp_d [3];
        logic ok, rv, rc;
        logic [7:0] d;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            do_push(1'b0, exp_d[i], ok);
            vectors++;
            if (ok !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_push%0d: gnt=%b want 1", i, ok);
            end
        end
        vectors++;
        if (count0 !== 8'd3 || empty0 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_count: got count0=%0d empty0=%b want 3 0", count0, empty0);
        end
        for (int i = 0; i < 3; i++) begin
            do_pop(1'b0, ok, rv, rc, d);
            vectors++;
            if ({ok, rv, rc, d} !== {1'b1, 1'b1, 1'b0, exp_d[i]}) begin
                miscompares++;
                $display("FAIL basic_pop%0d: got gnt=%b rvalid=%b rch=%b rdata=%h want 1 1 0 %h",
                         i, ok, rv, rc, d, exp_d[i]);
            end
        end
        tick();
        vectors++;
        if (rvalid !== 1'b0 || empty0 !== 1'b1 || count0 !== 8'd0) begin
            miscompares++;
            $display("FAIL basic_end: got rvalid=%b empty0=%b count0=%0d want 0 1 0", rvalid, empty0, count0);
        end
    endtask

    task automatic test_full_ch1();
        logic ok, rv, rc, seen;
        logic [7:0] d;
        int bad;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            do_push(1'b1, 8'(i), ok);
            if (!ok) bad++;
            if (i == 126) begin
                vectors++;
                if (full1 !== 1'b0 || count1 !== 8'd127) begin
                    miscompares++;
                    $display("FAIL full_at127: got full1=%b count1=%0d want 0 127", full1, count1);
                end
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL full_push_grants: got %0d ungranted pushes want 0", bad);
        end
        vectors++;
        if (full1 !== 1'b1 || count1 !== 8'd128 || empty0 !== 1'b1) begin
            miscompares++;
            $display("FAIL full_flags: got full1=%b count1=%0d empty0=%b want 1 128 1", full1, count1, empty0);
        end
        push1_req = 1'b1;
        push1_data = 8'hEE;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (push1_gnt !== 1'b0) seen = 1'b1;
            tick();
        end
        push1_req = 1'b0;
        vectors++;
        if (seen !== 1'b0 || count1 !== 8'd128) begin
            miscompares++;
            $display("FAIL full_129th: got granted=%b count1=%0d want 0 128", seen, count1);
        end
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            do_pop(1'b1, ok, rv, rc, d);
            if ({ok, rv, rc, d} !== {1'b1, 1'b1, 1'b1, 8'(i)}) begin
                bad++;
                if (bad < 4) $display("FAIL full_pop%0d: got gnt=%b rvalid=%b rch=%b rdata=%h want 1 1 1 %h",
                                      i, ok, rv, rc, d, 8'(i));
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL full_pop_seq: got %0d bad pops want 0", bad);
        end
        vectors++;
        if (empty1 !== 1'b1 || count1 !== 8'd0 || count0 !== 8'd0 || empty0 !== 1'b1) begin
            miscompares++;
            $display("FAIL full_drain: got empty1=%b count1=%0d count0=%0d empty0=%b want 1 0 0 1",
                     empty1, count1, count0, empty0);
        end
    endtask

    task automatic test_round_robin();
        logic ok, rv, rc;
        logic [7:0] d;
        logic [3:0] g, exp_g;
        apply_reset();
        for (int i = 0; i < 4; i++) do_push(1'b0, 8'h40 + 8'(i), ok);
        for (int i = 0; i < 5; i++) do_push(1'b1, 8'h50 + 8'(i), ok);
        do_pop(1'b1, ok, rv, rc, d);
        vectors++;
        if ({ok, rv, rc, d} !== {1'b1, 1'b1, 1'b1, 8'h50}) begin
            miscompares++;
            $display("FAIL rr_setup_pop: got gnt=%b rvalid=%b rch=%b rdata=%h want 1 1 1 50", ok, rv, rc, d);
        end
        push0_req = 1'b1; push0_data = 8'hA0;
        push1_req = 1'b1; push1_data = 8'hB0;
        pop0_req  = 1'b1;
        pop1_req  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            g = {pop1_gnt, push1_gnt, pop0_gnt, push0_gnt};
            exp_g = 4'b0001 << (k % 4);
            vectors++;
            if (g !== exp_g) begin
                miscompares++;
                $display("FAIL rr_cycle%0d: got {pop1,push1,pop0,push0}=%b want %b", k, g, exp_g);
            end
            tick();
        end
        clear_reqs();
        tick();
        vectors++;
        if (count0 !== 8'd4 || count1 !== 8'd4) begin
            miscompares++;
            $display("FAIL rr_counts: got count0=%0d count1=%0d want 4 4", count0, count1);
        end
    endtask

    task automatic test_wrap();
        logic ok, rv, rc;
        logic [7:0] d;
        int bad;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            do_push(1'b0, 8'(i), ok);
            if (!ok) bad++;
        end
        for (int i = 0; i < 100; i++) begin
            do_pop(1'b0, ok, rv, rc, d);
            if ({ok, rv, d} !== {1'b1, 1'b1, 8'(i)}) bad++;
        end
        for (int i = 0; i < 60; i++) begin
            do_push(1'b0, 8'hC0 ^ 8'(i), ok);
            if (!ok) bad++;
        end
        vectors++;
        if (count0 !== 8'd60 || count1 !== 8'd0 || empty1 !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_counts: got count0=%0d count1=%0d empty1=%b want 60 0 1", count0, count1, empty1);
        end
        for (int i = 0; i < 60; i++) begin
            do_pop(1'b0, ok, rv, rc, d);
            if ({ok, rv, rc, d} !== {1'b1, 1'b1, 1'b0, 8'hC0 ^ 8'(i)}) begin
                bad++;
                if (bad < 4) $display("FAIL wrap_pop%0d: got rdata=%h want %h", i, d, 8'hC0 ^ 8'(i));
            end
        end
        vectors++;
        if (bad != 0 || empty0 !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_order: got %0d errors empty0=%b want 0 1", bad, empty0);
        end
    endtask

    task automatic test_pop_empty_push();
        push0_req = 1'b1; push0_data = 8'h5A;
        pop0_req  = 1'b1;
        #1;
        vectors++;
        if ({push0_gnt, pop0_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL pe_same_cycle: got push0_gnt=%b pop0_gnt=%b want 1 0", push0_gnt, pop0_gnt);
        end
        tick();
        push0_req = 1'b0;
        #1;
        vectors++;
        if (pop0_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL pe_next_pop: got pop0_gnt=%b want 1", pop0_gnt);
        end
        tick();
        pop0_req = 1'b0;
        vectors++;
        if ({rvalid, rch, rdata} !== {1'b1, 1'b0, 8'h5A}) begin
            miscompares++;
            $display("FAIL pe_data: got rvalid=%b rch=%b rdata=%h want 1 0 5a", rvalid, rch, rdata);
        end
    endtask

    task automatic test_reset_mid_pop();
        logic ok;
        apply_reset();
        for (int i = 0; i < 5; i++) do_push(1'b0, 8'h70 + 8'(i), ok);
        vectors++;
        if (count0 !== 8'd5) begin
            miscompares++;
            $display("FAIL rmp_setup: got count0=%0d want 5", count0);
        end
        pop0_req = 1'b1;
        rst = 1'b1;
        #1;
        vectors++;
        if (pop0_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL rmp_gnt: got pop0_gnt=%b want 1", pop0_gnt);
        end
        tick();
        rst = 1'b0;
        pop0_req = 1'b0;
        vectors++;
        if ({rvalid, count0, empty0} !== {1'b0, 8'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL rmp_after: got rvalid=%b count0=%0d empty0=%b want 0 0 1", rvalid, count0, empty0);
        end
        tick();
        vectors++;
        if (rvalid !== 1'b0 || empty0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rmp_hold: got rvalid=%b empty0=%b want 0 1", rvalid, empty0);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_reqs();
        push0_data = '0;
        push1_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_ch0();
        test_full_ch1();
        test_round_robin();
        test_wrap();
        test_pop_empty_push();
        test_reset_mid_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_ram_arbiter.md
# fifo_ram_arbiter

Controller that shares one 256×8 single-port synchronous RAM between two logical FIFOs: channel 0 in addresses 0x00–0x7F and channel 1 in 0x80–0xFF. It owns all read/write pointers, occupancy counters and full/empty flags. It arbitrates four requesters (push0, pop0, push1, pop1) round-robin, one RAM access per cycle. It sits between the UART RX/TX paths and the buffer RAM, replacing per-path dedicated memories.

## Interface
- DATA_W, 8, data word width
- ADDR_W, 8, RAM address width; each channel depth = 2^(ADDR_W-1) = 128
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- push0_req / push1_req  input  1  request to write one word into channel 0/1
- push0_data / push1_data  input  DATA_W  word to write; sampled in the grant cycle
- push0_gnt / push1_gnt  output  1  combinational grant; word is accepted on this edge
- pop0_req / pop1_req  input  1  request to read one word from channel 0/1
- pop0_gnt / pop1_gnt  output  1  combinational grant; word is removed on this edge
- rdata  output  DATA_W  popped word, registered
- rvalid  output  1  rdata valid; high exactly one cycle, one cycle after a pop grant
- rch  output  1  channel of the current rdata
- full0 / full1, empty0 / empty1  output  1  registered occupancy flags
- count0 / count1  output  ADDR_W  occupancy, 0..128

## Operation
- Per channel: wptr and rptr, 7 bits each, wrapping 127→0. Physical address = {ch, ptr}. count is 8 bits.
- Request masking: a push request is eligible only when !full. A pop request is eligible only when !empty. Ineligible requests are ignored and never granted.
- Arbiter:
  - Request indices: 0=push0, 1=pop0, 2=push1, 3=pop1.
  - A last-grant register lg (2 bits) sets the search order: (lg+1), (lg+2), (lg+3), lg, mod 4.
  - The first eligible index in that order wins. At most one grant per cycle.
  - lg updates to the winner on a granting cycle and holds otherwise.
- Push grant:
  - RAM write at {ch,wptr} with the push data.
  - wptr+1, count+1.
- Pop grant:
  - RAM read at {ch,rptr}.
  - rptr+1, count−1.
  - Next cycle: rvalid=1, rch=ch, rdata=RAM output.
- Flags are derived from the next count and registered: full = (count==128), empty = (count==0).
- Requesters hold req until they see gnt. The block does not queue requests.
- Write followed by a read of the same address on the next cycle returns the newly written word. The write completes at the edge.
- Idle cycle (no eligible request): RAM is not enabled, rvalid=0, and rdata holds its last value.

## Timing
- Reset values:
  - All pointers 0, count0/1=0.
  - empty0/1=1, full0/1=0.
  - lg=3, so push0 has highest priority after reset.
  - rvalid=0, rch=0, rdata=0, all gnt=0.
- Reset mid-operation: a pop granted in the cycle where rst is high is discarded. rvalid stays 0 in the following cycle and contents are logically lost.
- gnt is combinational from req, flags and lg. It does not depend on the same-cycle pop.
- Pop latency: grant at edge N, data at edge N+1 (rvalid high for cycle N+1..N+2).
- Throughput: one access per cycle total. With all four eligible requests asserted continuously, each is granted once every 4 cycles.
- Boundary cases:
  - Push at count 127 sets full on the next cycle. A further push is not granted.
  - Pop at count 1 sets empty. A further pop is not granted.
  - Pointer wrap 127→0 stays inside its channel's half.

## Structure
- Package fifo_arb_pkg:
  - Request index constants REQ_PUSH0, REQ_POP0, REQ_PUSH1, REQ_POP1.
  - Default DATA_W/ADDR_W localparams.
  - A CH_DEPTH constant.
- Sub-module fifo_sp_ram: 2^ADDR_W × DATA_W single-port synchronous RAM with en, we, addr, wdata, and registered rdata that updates only when en && !we.
- The arbiter, pointers and counters stay in the top module.

## Test plan
- Reset, then push0 of 0x11, 0x22, 0x33, then three pop0 -> rdata 0x11, 0x22, 0x33, each one cycle after its grant. rch=0, and empty0=1 at the end.
- Push1 128 words 0x00..0x7F -> full1=1, count1=128, and a 129th push1 is never granted. Pop all -> same sequence, empty1=1, channel 0 unaffected.
- push0, pop0 (ch0 nonempty), push1 and pop1 held high for 8 cycles -> grants in order push0, pop0, push1, pop1 repeating, each twice.
- Fill ch0 to 100, pop 100, push 60 more -> wrap past address 0x7F to 0x00, and data order is preserved.
- pop0_req on empty channel with push0_req the same cycle -> push granted, pop not granted. The next cycle's pop returns the pushed word.
- Assert rst in the cycle of a pop grant with count0=5 -> rvalid=0 next cycle, count0=0, empty0=1.
